// File: rtl/dir_input_conditioner.sv
// dir_input_conditioner: synchronises and debounces four direction buttons.
// It keeps a one-hot (or all-zero) heading for the movement stage.
// Movement is gated by an IDLE/PLAY/DONE game-phase FSM.
// Optional macro STICKY_DIR_EN: when defined, the heading latches the most
// recent press. When undefined, the heading follows a single held button.
`timescale 1ns/1ps
module dir_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BtnL,
  input  logic       BtnU,
  input  logic       BtnR,
  input  logic       BtnD,
  input  logic       start,
  input  logic       ack,
  input  logic       win,
  input  logic       lose,
  output logic       Left,
  output logic       Up,
  output logic       Right,
  output logic       Down,
  output logic [1:0] dirCode,
  output logic       dirValid,
  output logic [1:0] phase
);

  localparam int unsigned NBTN = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button vector order: bit0=L, bit1=U, bit2=R, bit3=D (matches dirCode).
  logic [NBTN-1:0]  raw_c;
  logic [NBTN-1:0]  sync1;
  logic [NBTN-1:0]  sync2;
  logic [NBTN-1:0]  db;
  logic [CNT_W-1:0] cnt [NBTN];
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [NBTN-1:0]  heading;
  logic [NBTN-1:0]  heading_next;
  logic [1:0]       code_next;
`ifdef STICKY_DIR_EN
  logic [NBTN-1:0]  press;
`endif

  assign raw_c = {BtnD, BtnR, BtnU, BtnL};

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: accept a new level after DEBOUNCE_CYCLES stable samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db <= '0;
`ifdef STICKY_DIR_EN
      press <= '0;
`endif
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
`ifdef STICKY_DIR_EN
        press[i] <= 1'b0;
`endif
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
`ifdef STICKY_DIR_EN
          press[i] <= ~db[i];
`endif
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Phase transitions and next heading.
  always_comb begin
    state_next   = state;
    heading_next = heading;
    case (state)
      IDLE: begin
        heading_next = '0;
        if (start) state_next = PLAY;
      end
      PLAY: begin
        if (win || lose) begin
          state_next   = DONE;
          heading_next = '0;
        end else begin
`ifdef STICKY_DIR_EN
          if      (press[0]) heading_next = 4'b0001;
          else if (press[1]) heading_next = 4'b0010;
          else if (press[2]) heading_next = 4'b0100;
          else if (press[3]) heading_next = 4'b1000;
`else
          case (db)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: heading_next = db;
            default:                            heading_next = '0;
          endcase
`endif
        end
      end
      DONE: begin
        heading_next = '0;
        if (ack) state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        heading_next = '0;
      end
    endcase

    code_next = 2'd0;
    if      (heading_next[1]) code_next = 2'd1;
    else if (heading_next[2]) code_next = 2'd2;
    else if (heading_next[3]) code_next = 2'd3;
  end

  // Phase and heading registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      heading  <= '0;
      dirCode  <= 2'd0;
      dirValid <= 1'b0;
    end else begin
      state    <= state_next;
      heading  <= heading_next;
      dirCode  <= code_next;
      dirValid <= |heading_next;
    end
  end

  assign phase = state;
  assign Left  = heading[0];
  assign Up    = heading[1];
  assign Right = heading[2];
  assign Down  = heading[3];

endmodule
